// File: rtl/branch_check_queue_pkg.sv
// Shared definitions for the branch check queue: branch type codes,
// the queue entry layout and the sequential next-PC helper.
package branch_check_queue_pkg;

    localparam int PCSIZE_DEF = 12;

    // Branch type codes carried on res_branch / upd_branch.
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_COND = 3'b001;
    localparam logic [2:0] BR_JUMP = 3'b010;
    localparam logic [2:0] BR_CALL = 3'b011;
    localparam logic [2:0] BR_RET  = 3'b100;

    // One in-flight prediction as captured at fetch.
    typedef struct packed {
        logic [PCSIZE_DEF-1:0] pc;
        logic                  pred;
        logic [PCSIZE_DEF-1:0] next;
    } bcq_entry_t;

    localparam int ENTRY_W = $bits(bcq_entry_t);

    // Fall-through PC; wraps modulo 2^PCSIZE like the fetch adder.
    function automatic logic [PCSIZE_DEF-1:0] seq_next(input logic [PCSIZE_DEF-1:0] pc);
        return pc + PCSIZE_DEF'(4);
    endfunction

endpackage

// File: rtl/branch_check_queue_if.sv
// Fetch/execute-facing bundle of the branch check queue.
//
// Handshake: a push transfers on a rising edge where push_valid and
// push_ready are both high; push_valid and the push payload must be held
// stable by the master until that edge, and push_ready never depends on
// push_valid. res_valid is a one-sided strobe (no ready): it is consumed
// when the queue holds an entry and silently ignored when it is empty.
// upd_valid and flush are single-cycle pulses with no back-pressure.
interface branch_check_queue_if #(
    parameter int PCSIZE = 12
);
    logic              push_valid;
    logic              push_ready;
    logic [PCSIZE-1:0] push_pc;
    logic              push_pred;
    logic [PCSIZE-1:0] push_next;

    logic              res_valid;
    logic [2:0]        res_branch;
    logic              res_taken;
    logic [PCSIZE-1:0] res_target;

    logic              upd_valid;
    logic [PCSIZE-1:0] upd_pc;
    logic [2:0]        upd_branch;
    logic              upd_outcome;
    logic [PCSIZE-1:0] upd_target;

    logic              flush;
    logic [PCSIZE-1:0] redirect_pc;

    // Fetch / execute side.
    modport master (
        output push_valid, push_pc, push_pred, push_next,
        output res_valid, res_branch, res_taken, res_target,
        input  push_ready,
        input  upd_valid, upd_pc, upd_branch, upd_outcome, upd_target,
        input  flush, redirect_pc
    );

    // Queue side.
    modport slave (
        input  push_valid, push_pc, push_pred, push_next,
        input  res_valid, res_branch, res_taken, res_target,
        output push_ready,
        output upd_valid, upd_pc, upd_branch, upd_outcome, upd_target,
        output flush, redirect_pc
    );
endinterface

// File: rtl/branch_check_queue_pred_fifo.sv
// Generic DEPTH-entry circular buffer with push, pop, synchronous clear
// and an occupancy count. Clear wins over push and pop in the same cycle.
module branch_check_queue_pred_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/branch_check_queue.sv
// Branch check queue: holds fetch-time predictions until execute resolves
// them, emits a training pulse for the predictor/BTB and a flush/redirect
// to fetch when the predicted next PC turns out to be wrong.
module branch_check_queue
    import branch_check_queue_pkg::*;
#(
    parameter int PCSIZE = PCSIZE_DEF,
    parameter int DEPTH  = 4,
    parameter int CNTW   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_check_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNTW-1:0]        mispred_cnt
);
    // The entry struct is laid out at the package PC width.
    if (PCSIZE != PCSIZE_DEF) begin : g_width_check
        $error("branch_check_queue: PCSIZE must equal PCSIZE_DEF");
    end

    bcq_entry_t        push_entry;
    bcq_entry_t        head;
    logic [ENTRY_W-1:0] head_bits;
    logic              fifo_full;
    logic              fifo_empty;

    logic              push_fire;
    logic              pop_fire;
    logic              mispredict;
    logic [PCSIZE-1:0] actual_next;

    logic              upd_valid_q;
    logic [PCSIZE-1:0] upd_pc_q;
    logic [2:0]        upd_branch_q;
    logic              upd_outcome_q;
    logic [PCSIZE-1:0] upd_target_q;
    logic              flush_q;
    logic [PCSIZE-1:0] redirect_q;

    assign push_entry = '{pc: bus.push_pc, pred: bus.push_pred, next: bus.push_next};
    assign head       = bcq_entry_t'(head_bits);

    // No new predictions while full or while fetch is being redirected.
    assign bus.push_ready = !fifo_full && !flush_q;

    // Resolve the oldest entry: compute the real next PC and compare.
    always_comb begin
        push_fire   = bus.push_valid && bus.push_ready;
        pop_fire    = bus.res_valid && !fifo_empty;
        actual_next = bus.res_taken ? bus.res_target : seq_next(head.pc);
        mispredict  = pop_fire && (actual_next != head.next);
    end

    // A mispredict clears the whole queue (younger entries are wrong-path)
    // and drops any push in the same cycle.
    branch_check_queue_pred_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_fire && !mispredict),
        .din   (push_entry),
        .pop   (pop_fire && !mispredict),
        .clear (mispredict),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    // Training pulse and its payload; payload holds between pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_branch_q  <= BR_NONE;
            upd_outcome_q <= 1'b0;
            upd_target_q  <= '0;
        end else begin
            upd_valid_q <= pop_fire && (bus.res_branch != BR_NONE);
            if (pop_fire) begin
                upd_pc_q      <= head.pc;
                upd_branch_q  <= bus.res_branch;
                upd_outcome_q <= bus.res_taken;
                upd_target_q  <= bus.res_target;
            end
        end
    end

    // Flush pulse, redirect target and saturating mispredict statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            mispred_cnt <= '0;
        end else begin
            flush_q <= mispredict;
            if (mispredict) begin
                redirect_q <= actual_next;
                if (mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNTW'(1);
            end
        end
    end

    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_branch  = upd_branch_q;
    assign bus.upd_outcome = upd_outcome_q;
    assign bus.upd_target  = upd_target_q;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;

    logic unused_pred;
    assign unused_pred = head.pred;

endmodule

// File: tb/tb_branch_check_queue.sv
// Bench for branch_check_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_branch_check_queue;

    localparam int PCSIZE = 12;
    localparam int DEPTH  = 4;
    localparam int CNTW   = 4;
    localparam int CMAX   = (1 << CNTW) - 1;
    localparam int W      = 2*PCSIZE + 4;

    typedef struct {
        logic [PCSIZE-1:0] pc;
        logic              pred;
        logic [PCSIZE-1:0] next;
    } ent_t;

    logic clk;
    logic rst_n;
    logic [$clog2(DEPTH):0] occupancy;
    logic [CNTW-1:0]        mispred_cnt;

    branch_check_queue_if #(.PCSIZE(PCSIZE)) bus();

    branch_check_queue #(.PCSIZE(PCSIZE), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .occupancy   (occupancy),
        .mispred_cnt (mispred_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model + scoreboard ----------------
    ent_t         mq[$];
    logic         mflush;
    int           mcnt;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mflush = 1'b0;
        mcnt   = 0;
    endtask

    // ---------------- driver tasks ----------------
    // One clock of stimulus; the model is stepped before the edge and the
    // DUT outputs are compared just after it.
    task automatic cycle(input logic pv, input logic [PCSIZE-1:0] pc, input logic pred,
                         input logic [PCSIZE-1:0] nxt, input logic rv, input logic [2:0] br,
                         input logic tk, input logic [PCSIZE-1:0] tgt);
        logic              pr, acc, e_upd, e_flush;
        logic [PCSIZE-1:0] e_redir, an;
        ent_t              h, ne;
        @(negedge clk);
        bus.push_valid = pv;  bus.push_pc = pc;  bus.push_pred = pred;  bus.push_next = nxt;
        bus.res_valid  = rv;  bus.res_branch = br; bus.res_taken = tk;  bus.res_target = tgt;
        #1;
        pr = (mq.size() < DEPTH) && !mflush;
        check("push_ready", bus.push_ready, pr);
        acc = pv && pr;
        ne = '{pc: pc, pred: pred, next: nxt};
        e_upd = 1'b0; e_flush = 1'b0; e_redir = '0;
        if (rv && mq.size() > 0) begin
            h  = mq[0];
            an = tk ? tgt : PCSIZE'(h.pc + 12'd4);
            if (br != 3'b000) begin
                e_upd = 1'b1;
                exp_q.push_back({h.pc, br, tk, tgt});
            end
            if (an != h.next) begin
                mq.delete();
                e_flush = 1'b1;
                e_redir = an;
                if (mcnt < CMAX) mcnt++;
            end else begin
                void'(mq.pop_front());
                if (acc) mq.push_back(ne);
            end
        end else if (acc) begin
            mq.push_back(ne);
        end
        mflush = e_flush;
        @(posedge clk);
        #1;
        check("flush", bus.flush, e_flush);
        if (e_flush) check("redirect_pc", bus.redirect_pc, e_redir);
        check("upd_valid", bus.upd_valid, e_upd);
        if (e_upd && bus.upd_valid && exp_q.size() > 0)
            check("upd_payload", {bus.upd_pc, bus.upd_branch, bus.upd_outcome, bus.upd_target},
                  exp_q.pop_front());
        check("occupancy", occupancy, mq.size());
        check("mispred_cnt", mispred_cnt, mcnt);
    endtask

    task automatic push(input logic [PCSIZE-1:0] pc, input logic [PCSIZE-1:0] nxt);
        cycle(1'b1, pc, 1'b0, nxt, 1'b0, 3'b000, 1'b0, '0);
    endtask

    task automatic resolve(input logic [2:0] br, input logic tk, input logic [PCSIZE-1:0] tgt);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, br, tk, tgt);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 1'b0, 3'b000, 1'b0, '0);
    endtask

    task automatic drive_zero();
        bus.push_valid = 1'b0; bus.push_pc = '0; bus.push_pred = 1'b0; bus.push_next = '0;
        bus.res_valid  = 1'b0; bus.res_branch = '0; bus.res_taken = 1'b0; bus.res_target = '0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        drive_zero();
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_flush"}, bus.flush, 1'b0);
        check({tag, "_upd_valid"}, bus.upd_valid, 1'b0);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_mispred_cnt"}, mispred_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [PCSIZE-1:0] rpc, rnx, rtg;
        rst_n = 1'b0;
        drive_zero();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupancy", occupancy, 0);
        check("rst_flush", bus.flush, 1'b0);
        check("rst_upd_valid", bus.upd_valid, 1'b0);
        check("rst_redirect", bus.redirect_pc, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct not-taken prediction trains without flushing.
        push(12'h010, 12'h014);
        resolve(3'b001, 1'b0, 12'h000);
        check("t1_upd_valid", bus.upd_valid, 1'b1);
        check("t1_upd_pc", bus.upd_pc, 12'h010);
        check("t1_upd_outcome", bus.upd_outcome, 1'b0);
        check("t1_flush", bus.flush, 1'b0);

        // Taken branch predicted not-taken: flush with redirect.
        push(12'h020, 12'h024);
        resolve(3'b001, 1'b1, 12'h100);
        check("t2_flush", bus.flush, 1'b1);
        check("t2_redirect", bus.redirect_pc, 12'h100);
        check("t2_upd_target", bus.upd_target, 12'h100);
        check("t2_mispred_cnt", mispred_cnt, 1);
        idle();
        check("t2_flush_drop", bus.flush, 1'b0);

        // Fill to DEPTH; extra push refused; pop+push while full only pops.
        for (int i = 0; i < 4; i++) push(PCSIZE'(12'h100 + 4*i), PCSIZE'(12'h104 + 4*i));
        push(12'h200, 12'h204);
        check("t3_full_occ", occupancy, 4);
        cycle(1'b1, 12'h300, 1'b0, 12'h304, 1'b1, 3'b010, 1'b0, 12'h000);
        check("t3_occ_after", occupancy, 3);
        repeat (3) resolve(3'b001, 1'b0, 12'h000);

        // Mispredict with younger entries and a concurrent push.
        for (int i = 0; i < 3; i++) push(PCSIZE'(12'h400 + 4*i), PCSIZE'(12'h404 + 4*i));
        cycle(1'b1, 12'h500, 1'b0, 12'h504, 1'b1, 3'b001, 1'b1, 12'h200);
        check("t4_occ_cleared", occupancy, 0);
        push(12'h510, 12'h514);
        check("t4_push_blocked", occupancy, 0);
        push(12'h520, 12'h524);
        check("t4_push_resumed", occupancy, 1);
        resolve(3'b001, 1'b0, 12'h000);

        // Fall-through wrap, then resolve on an empty queue.
        push(12'hFFC, 12'h000);
        resolve(3'b001, 1'b0, 12'h000);
        check("t5_wrap_no_flush", bus.flush, 1'b0);
        resolve(3'b011, 1'b1, 12'h040);
        check("t5_empty_no_upd", bus.upd_valid, 1'b0);

        // Reset mid-operation with two entries held.
        push(12'h600, 12'h604);
        push(12'h608, 12'h60C);
        mid_reset("t6a");
        // Reset while a flush pulse is being driven.
        push(12'h700, 12'h704);
        push(12'h708, 12'h70C);
        resolve(3'b001, 1'b1, 12'h7F0);
        mid_reset("t6b");

        // Random traffic, including branch type 0 and saturation of the counter.
        for (int n = 0; n < 600; n++) begin
            rpc = PCSIZE'($urandom) & 12'hFFC;
            rnx = ($urandom_range(0, 99) < 50) ? PCSIZE'(rpc + 12'd4) : (PCSIZE'($urandom) & 12'hFFC);
            rtg = (mq.size() > 0 && $urandom_range(0, 99) < 50) ? mq[0].next
                                                                 : (PCSIZE'($urandom) & 12'hFFC);
            cycle(($urandom_range(0, 99) < 60), rpc, 1'($urandom), rnx,
                  ($urandom_range(0, 99) < 45), 3'($urandom_range(0, 4)), 1'($urandom), rtg);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
